// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer encodings and slave state type
package ahb_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE = 2'b00, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} slave_state_t;
endpackage

// File: rtl/ahb_byte_lane_decoder.sv
// ahb_byte_lane_decoder: maps transfer size and low address bits to byte strobes and a size/alignment error
module ahb_byte_lane_decoder
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       err
);
  always_comb begin
    strb = hsize == HSIZE_BYTE ? 4'b0001 << addr :
           hsize == HSIZE_HALF ? 4'b0011 << addr :
           hsize == HSIZE_WORD ? 4'b1111 : 4'b0000;
    err = hsize > HSIZE_WORD || (hsize == HSIZE_HALF && addr[0]) || (hsize == HSIZE_WORD && addr != 2'b00);
  end
endmodule

// File: rtl/ahb_ram_slave.sv
// ahb_ram_slave: AHB-Lite RAM slave with programmable data-phase wait states and byte-lane writes
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hB000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic [3:0]  hprot,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  slave_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] d_idx;
  logic d_write;
  logic [3:0] d_strb, strb;
  logic lane_err, legal, done, take;
  logic [31:0] mem [DEPTH_WORDS];
  logic unused;
  assign unused = ^{hprot, htrans[0]};
  ahb_byte_lane_decoder u_dec (
    .hsize(hsize),
    .addr(haddr[1:0]),
    .strb(strb),
    .err(lane_err)
  );
  // a new address phase is only accepted when no data phase is still stalling
  always_comb begin
    legal = !lane_err && haddr[31:24] == BASE_ADDR[31:24] && {10'd0, haddr[23:2]} < DEPTH_LIM;
    done = state == ST_DATA && cnt == 4'd0;
    take = hsel && htrans[1] && hready && (state == ST_IDLE || state == ST_ERR2 || done);
    state_n = take ? (legal ? ST_DATA : ST_ERR1) :
              state == ST_ERR1 ? ST_ERR2 :
              (state == ST_DATA && !done) ? ST_DATA : ST_IDLE;
    cnt_n = take && legal ? WS : cnt != 4'd0 ? cnt - 4'd1 : 4'd0;
    hreadyout = state == ST_DATA ? done : state != ST_ERR1;
    hresp = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    hrdata = done && !d_write ? mem[d_idx] : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_ff @(posedge clk) begin
    if (take) begin
      d_idx <= haddr[2 +: AW];
      d_write <= hwrite;
      d_strb <= strb;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && done && d_write)
      for (int i = 0; i < 4; i++)
        if (d_strb[i]) mem[d_idx][8*i +: 8] <= hwdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_ram_slave.sv
// tb_ahb_ram_slave: table-driven AHB transfers against three wait-state variants with a data-phase scoreboard
module tb_ahb_ram_slave;
  import ahb_pkg::*;
  typedef struct {
    int d;
    logic w;
    logic [2:0] sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic err;
    string name;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0;
  int sel = 0;
  logic [1:0] htrans = 2'b00;
  logic [31:0] haddr = 32'd0, hwdata = 32'd0;
  logic hwrite = 1'b0;
  logic [2:0] hsize = 3'd0;
  logic [3:0] hprot = 4'b0011;
  logic hready;
  logic [31:0] hrdata_v [3];
  logic hreadyout_v [3];
  logic hresp_v [3];
  vec_t q[$];
  vec_t tv[$];
  int ntests = 0, nfail = 0;
  always #5 clk = ~clk;
  assign hready = hreadyout_v[0] & hreadyout_v[1] & hreadyout_v[2] & ~stall;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_ram_slave #(.WAIT_STATES(g == 0 ? 0 : g + 1)) dut (
      .clk(clk),
      .rst(rst),
      .hsel(sel == g),
      .htrans(htrans),
      .haddr(haddr),
      .hwrite(hwrite),
      .hsize(hsize),
      .hwdata(hwdata),
      .hprot(hprot),
      .hready(hready),
      .hrdata(hrdata_v[g]),
      .hreadyout(hreadyout_v[g]),
      .hresp(hresp_v[g])
    );
  end
  function automatic int ws(input int d);
    return d == 0 ? 0 : d + 1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic err, input string name);
    vec_t v;
    v.d = d; v.w = w; v.sz = sz; v.a = a; v.wd = wd; v.rd = rd; v.err = err; v.name = name;
    tv.push_back(v);
  endtask
  task automatic issue(input vec_t v);
    int n = 0;
    sel = v.d; htrans = 2'b10; haddr = v.a; hwrite = v.w; hsize = v.sz;
    @(negedge clk);
    while (!hready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk({v.name, "_accept_timeout"}, 32'(n), 32'd0);
    @(posedge clk);
    #1;
    q.push_back(v);
    hwdata = v.wd;
    htrans = 2'b00;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask
  // scoreboard: each queued transfer is checked over its whole data phase
  initial begin
    int waits = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        if (!hreadyout_v[q[0].d]) begin
          waits++;
          chk({q[0].name, "_hresp_wait"}, 32'(hresp_v[q[0].d]), 32'(q[0].err));
          if (waits > 20) begin
            chk({q[0].name, "_timeout"}, 32'(waits), 32'd0);
            void'(q.pop_front());
            waits = 0;
          end
        end else begin
          chk({q[0].name, "_waits"}, 32'(waits), 32'(q[0].err ? 1 : ws(q[0].d)));
          chk({q[0].name, "_hresp"}, 32'(hresp_v[q[0].d]), 32'(q[0].err));
          chk({q[0].name, "_hrdata"}, hrdata_v[q[0].d], q[0].rd);
          void'(q.pop_front());
          waits = 0;
        end
      end
    end
  end
  initial begin
    add(0, 1'b1, HSIZE_WORD, 32'hB000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, "w_word");
    add(0, 1'b0, HSIZE_WORD, 32'hB000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, "r_word");
    add(0, 1'b1, HSIZE_WORD, 32'hB000_0020, 32'h1122_3344, 32'h0,         1'b0, "w_merge_base");
    add(0, 1'b1, HSIZE_BYTE, 32'hB000_0023, 32'hAB00_0000, 32'h0,         1'b0, "w_byte3");
    add(0, 1'b0, HSIZE_WORD, 32'hB000_0020, 32'h0,         32'hAB22_3344, 1'b0, "r_merge");
    add(0, 1'b1, HSIZE_WORD, 32'hB000_0000, 32'hCAFE_F00D, 32'h0,         1'b0, "w_word0");
    add(0, 1'b1, HSIZE_HALF, 32'hB000_0001, 32'h1234_5678, 32'h0,         1'b1, "w_half_misaligned");
    add(0, 1'b0, HSIZE_WORD, 32'hB000_0000, 32'h0,         32'hCAFE_F00D, 1'b0, "r_after_err");
    add(0, 1'b0, HSIZE_WORD, 32'hC000_0000, 32'h0,         32'h0,         1'b1, "r_bad_region");
    add(0, 1'b0, HSIZE_WORD, 32'hB000_1000, 32'h0,         32'h0,         1'b1, "r_index_depth");
    add(0, 1'b1, HSIZE_HALF, 32'hB000_0022, 32'h5566_0000, 32'h0,         1'b0, "w_half_upper");
    add(0, 1'b0, HSIZE_WORD, 32'hB000_0020, 32'h0,         32'h5566_3344, 1'b0, "r_half_merge");
    add(0, 1'b0, 3'b011,     32'hB000_0000, 32'h0,         32'h0,         1'b1, "r_bad_size");
    add(0, 1'b0, HSIZE_WORD, 32'hB000_0002, 32'h0,         32'h0,         1'b1, "r_word_misaligned");
    add(0, 1'b1, HSIZE_WORD, 32'hB000_0040, 32'h0000_0000, 32'h0,         1'b0, "w_clear40");
    add(0, 1'b1, HSIZE_BYTE, 32'hB000_0041, 32'h0000_7700, 32'h0,         1'b0, "w_byte1");
    add(0, 1'b0, HSIZE_WORD, 32'hB000_0040, 32'h0,         32'h0000_7700, 1'b0, "r_byte1");
    add(1, 1'b1, HSIZE_WORD, 32'hB000_0030, 32'hA5A5_5A5A, 32'h0,         1'b0, "ws2_w");
    add(1, 1'b0, HSIZE_WORD, 32'hB000_0030, 32'h0,         32'hA5A5_5A5A, 1'b0, "ws2_r");
    add(1, 1'b0, HSIZE_WORD, 32'hC000_0000, 32'h0,         32'h0,         1'b1, "ws2_r_err");
    add(2, 1'b1, HSIZE_WORD, 32'hB000_0050, 32'h1357_9BDF, 32'h0,         1'b0, "ws3_w");
    add(2, 1'b0, HSIZE_WORD, 32'hB000_0050, 32'h0,         32'h1357_9BDF, 1'b0, "ws3_r");
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_hreadyout_%0d", i), 32'(hreadyout_v[i]), 32'd1);
      chk($sformatf("reset_hresp_%0d", i), 32'(hresp_v[i]), 32'd0);
      chk($sformatf("reset_hrdata_%0d", i), hrdata_v[i], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (tv[i]) issue(tv[i]);
    drain();
    // stalled bus: the address phase must not be taken
    sel = 2; htrans = 2'b10; hwrite = 1'b0; haddr = 32'hB000_0050; hsize = HSIZE_WORD; stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_no_capture_ready", 32'(hreadyout_v[2]), 32'd1);
    chk("stall_no_capture_hresp", 32'(hresp_v[2]), 32'd0);
    htrans = 2'b00; stall = 1'b0;
    @(posedge clk);
    #1;
    sel = 2; htrans = 2'b10; hwrite = 1'b1; haddr = 32'hB000_0050; hsize = HSIZE_WORD;
    @(posedge clk);
    #1;
    htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("rst_mid_wait_busy", 32'(hreadyout_v[2]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_wait_ready", 32'(hreadyout_v[2]), 32'd1);
    chk("rst_mid_wait_hresp", 32'(hresp_v[2]), 32'd0);
    chk("rst_mid_wait_hrdata", hrdata_v[2], 32'd0);
    begin
      vec_t v;
      v.d = 2; v.w = 1'b0; v.sz = HSIZE_WORD; v.a = 32'hB000_0050; v.wd = 32'h0;
      v.rd = 32'h1357_9BDF; v.err = 1'b0; v.name = "rst_readback";
      issue(v);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/ahb_ram_slave.md
Name: ahb_ram_slave

Overview:
- AHB-Lite slave for the RAM region (0xB000_0000 window).
- Sits directly downstream of the master glue logic. Consumes its htrans/haddr/hwrite/hsize/hwdata/hprot and returns hrdata/hreadyout/hresp.
- Standard two-stage address/data pipeline, programmable wait states, byte-lane writes.
- Returns full 32-bit words. Byte/half extraction and sign extension are done upstream.

Parameters:
- BASE_ADDR, 32'hB000_0000, start of decoded region; compared on haddr[31:24].
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two.
- WAIT_STATES, 0, data-phase wait cycles inserted per OKAY transfer (0..15).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- hsel  input  1  slave select from address decoder.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- haddr  input  32  transfer address.
- hwrite  input  1  1=write, 0=read.
- hsize  input  3  000=byte, 001=half, 010=word; others are illegal.
- hwdata  input  32  write data, valid in data phase.
- hprot  input  4  accepted and ignored.
- hready  input  1  bus-level ready (previous transfer completing).
- hrdata  output  32  read data; valid when hreadyout=1 in a read data phase.
- hreadyout  output  1  slave ready.
- hresp  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Address-phase capture:
  - Condition: hsel && htrans[1] && hready.
  - Registers haddr, hwrite, hsize; sets the data-phase-pending state.
  - IDLE/BUSY, or hsel=0, captures nothing. The next cycle is OKAY with zero wait.
- Legality is checked at capture. Any of the following is illegal:
  - hsize > 010.
  - Misalignment: half with haddr[0]=1, or word with haddr[1:0]!=0.
  - Out of range: haddr[31:24]!=BASE_ADDR[31:24], or word index >= DEPTH_WORDS.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0.
    - Legal capture -> DATA, wait counter loaded with WAIT_STATES.
    - Illegal capture -> ERR1.
  - DATA: hreadyout = (cnt==0); cnt decrements while nonzero.
    - On the cycle cnt==0 the transfer completes.
      - Write: commits hwdata to the byte lanes given by the strobe.
      - Read: hrdata = mem[word index], full word.
    - On completion, a new legal capture in the same cycle -> DATA (pipelined back-to-back); an illegal one -> ERR1; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1.
    - A capture in this cycle is evaluated as from IDLE; otherwise -> IDLE.
    - The master may drive IDLE in this cycle; that is honoured.
- Errors: no memory write occurs on any error transfer; hrdata=0 during error.
- Byte strobes:
  - byte: 1 << addr[1:0].
  - half: 0011 << addr[1:0].
  - word: 1111.
  - hwdata lanes are used in place; no shifting.
- Memory:
  - Read is combinational from the registered word index during the data phase.
  - A write completing at edge N is visible to a read whose data phase is cycle N+1 or later. No forwarding is needed.
- hrdata outside a completing read data phase: 0.
- Reset:
  - State -> IDLE, hreadyout=1, hresp=0, hrdata=0, cnt=0.
  - Any pending transfer is abandoned with no write.
  - RAM contents are not cleared.
- hready=0 while hsel=1 (another slave stalling): no capture; current state holds.

Decomposition:
- ahb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE_BYTE/HALF/WORD constants.
  - HRESP_OKAY/ERROR constants.
  - slave_state_t enum.
- Sub-module ahb_byte_lane_decoder: combinational. (hsize, addr[1:0]) -> strobe[3:0] plus misaligned/illegal-size flag. Reused by the ROM slave.

Test Plan:
- Word write then read, WAIT_STATES=0:
  - Write 0xDEAD_BEEF to 0xB000_0010, then read 0xB000_0010.
  - Expect hrdata=0xDEAD_BEEF in the read data phase, hreadyout=1 every cycle.
- Byte merge:
  - Word write 0x1122_3344 to 0xB000_0020, then byte write hwdata=0xAB00_0000 at 0xB000_0023, then word read.
  - Expect 0xAB22_3344.
- Misaligned half:
  - Half write at 0xB000_0001.
  - Expect hreadyout/hresp = 0/1 then 1/1; a subsequent word read of 0xB000_0000 returns the prior contents.
- WAIT_STATES=2 pipelined:
  - NONSEQ write A then read A back-to-back.
  - Expect hreadyout low 2 cycles per data phase and the read returns the write data.
- Out of range:
  - Read 0xC000_0000 or word index DEPTH_WORDS.
  - Expect a two-cycle ERROR and hrdata=0.
- Reset mid-wait:
  - WAIT_STATES=3, assert rst during the write data phase with cnt=2.
  - Next cycle hreadyout=1, hresp=0, and the target word is unchanged.
